// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the register file's single write port (AD3/WE3/WD3),
// with load-over-ALU arbitration and youngest-entry forwarding for the read ports.
module wb_write_queue #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]     alu_rd,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  output logic                         alu_ready,
  input  logic                         ld_valid,
  input  logic [ADDRESS_WIDTH-1:0]     ld_rd,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  output logic                         ld_ready,
  input  logic                         port_busy,
  output logic                         WE3,
  output logic [ADDRESS_WIDTH-1:0]     AD3,
  output logic [DATA_WIDTH-1:0]        WD3,
  input  logic [ADDRESS_WIDTH-1:0]     rs1,
  input  logic [ADDRESS_WIDTH-1:0]     rs2,
  output logic                         fwd1_hit,
  output logic [DATA_WIDTH-1:0]        fwd1_data,
  output logic                         fwd2_hit,
  output logic [DATA_WIDTH-1:0]        fwd2_data,
  output logic [$clog2(DEPTH):0]       pending
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [PtrW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]          count_q, count_d;

  logic                     pop, space;
  logic                     ld_acc, alu_acc, enq_acc, enq_store;
  logic [ADDRESS_WIDTH-1:0] enq_rd;
  logic [DATA_WIDTH-1:0]    enq_data;
  logic [PtrW-1:0]          idx;

  assign pop   = (count_q != '0) && !port_busy;
  assign space = (count_q < Full) || pop;

  assign ld_ready  = space;
  assign alu_ready = space && !ld_valid;
  assign ld_acc    = ld_valid && ld_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign enq_acc   = ld_acc || alu_acc;
  assign enq_rd    = ld_acc ? ld_rd : alu_rd;
  assign enq_data  = ld_acc ? ld_data : alu_data;
  // Writes to r0 are acknowledged but dropped; they never occupy a slot.
  assign enq_store = enq_acc && (enq_rd != '0);

  assign WE3     = pop;
  assign AD3     = (count_q != '0) ? rd_q[head_q] : '0;
  assign WD3     = (count_q != '0) ? data_q[head_q] : '0;
  assign pending = count_q;

  always_comb begin
    head_d  = pop ? head_q + PtrW'(1) : head_q;
    tail_d  = enq_store ? tail_q + PtrW'(1) : tail_q;
    count_d = count_q + CntW'(enq_store) - CntW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq_store) begin
        rd_q[tail_q]   <= enq_rd;
        data_q[tail_q] <= enq_data;
      end
    end
  end

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if ((rs1 != '0) && (rd_q[idx] == rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[idx];
        end
        if ((rs2 != '0) && (rd_q[idx] == rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4, 32-bit data, 5-bit index).
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, port_busy;
  logic [4:0]  alu_rd, ld_rd, rs1, rs2;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, WE3, fwd1_hit, fwd2_hit;
  logic [4:0]  AD3;
  logic [31:0] WD3, fwd1_data, fwd2_data;
  logic [2:0]  pending;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  wb_write_queue #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(5),
    .DEPTH        (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .ld_valid (ld_valid),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .port_busy(port_busy),
    .WE3      (WE3),
    .AD3      (AD3),
    .WD3      (WD3),
    .rs1      (rs1),
    .rs2      (rs2),
    .fwd1_hit (fwd1_hit),
    .fwd1_data(fwd1_data),
    .fwd2_hit (fwd2_hit),
    .fwd2_data(fwd2_data),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_req(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    port_busy = 1'b0; rs1 = '0; rs2 = '0;
    #12;
    rst = 1'b0;
    #1;
    check("rst_we3", {31'd0, WE3}, 32'd0);
    check("rst_ad3", {27'd0, AD3}, 32'd0);
    check("rst_wd3", WD3, 32'd0);
    check("rst_pending", {29'd0, pending}, 32'd0);
    check("rst_fwd1", {31'd0, fwd1_hit}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);

    // Single ALU write.
    tick();
    alu_req(1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_req(1'b0, 5'd0, 32'd0);
    #1;
    check("t1_we3", {31'd0, WE3}, 32'd1);
    check("t1_ad3", {27'd0, AD3}, 32'd5);
    check("t1_wd3", WD3, 32'hDEADBEEF);
    check("t1_pending1", {29'd0, pending}, 32'd1);
    tick();
    check("t1_we3_off", {31'd0, WE3}, 32'd0);
    check("t1_pending0", {29'd0, pending}, 32'd0);

    // Load beats ALU.
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
    alu_req(1'b1, 5'd4, 32'h22);
    #1;
    check("t2_ld_ready", {31'd0, ld_ready}, 32'd1);
    check("t2_alu_ready", {31'd0, alu_ready}, 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    check("t2_alu_ready2", {31'd0, alu_ready}, 32'd1);
    check("t2_ad3_ld", {27'd0, AD3}, 32'd3);
    check("t2_wd3_ld", WD3, 32'h11);
    check("t2_pending_a", {29'd0, pending}, 32'd1);
    tick();
    alu_req(1'b0, 5'd0, 32'd0);
    #1;
    check("t2_we3_alu", {31'd0, WE3}, 32'd1);
    check("t2_ad3_alu", {27'd0, AD3}, 32'd4);
    check("t2_wd3_alu", WD3, 32'h22);
    check("t2_pending_b", {29'd0, pending}, 32'd1);
    tick();
    check("t2_we3_off", {31'd0, WE3}, 32'd0);
    check("t2_pending0", {29'd0, pending}, 32'd0);

    // Fill while port borrowed, then drain with push+pop on the release cycle.
    port_busy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      alu_req(1'b1, 5'(k), 32'(k * 256));
      #1 check($sformatf("t3_acc%0d", k), {31'd0, alu_ready}, 32'd1);
      tick();
    end
    alu_req(1'b1, 5'd5, 32'h500);
    #1;
    check("t3_full_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("t3_full_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("t3_full_pending", {29'd0, pending}, 32'd4);
    check("t3_busy_we3", {31'd0, WE3}, 32'd0);
    port_busy = 1'b0;
    #1;
    check("t3_release_ready", {31'd0, alu_ready}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("t3_we3_%0d", k), {31'd0, WE3}, 32'd1);
      check($sformatf("t3_ad3_%0d", k), {27'd0, AD3}, 32'(k));
      check($sformatf("t3_wd3_%0d", k), WD3, 32'(k * 256));
      check($sformatf("t3_pend_%0d", k), {29'd0, pending}, (k == 1) ? 32'd4 : 32'(6 - k));
      tick();
      alu_req(1'b0, 5'd0, 32'd0);
      #1;
    end
    check("t3_drained", {29'd0, pending}, 32'd0);
    check("t3_we3_off", {31'd0, WE3}, 32'd0);

    // Forwarding picks the youngest of two r7 entries.
    port_busy = 1'b1;
    alu_req(1'b1, 5'd7, 32'h1);
    tick();
    alu_req(1'b1, 5'd7, 32'h2);
    tick();
    alu_req(1'b0, 5'd0, 32'd0);
    rs1 = 5'd7; rs2 = 5'd0;
    #1;
    check("t4_hit1", {31'd0, fwd1_hit}, 32'd1);
    check("t4_data1", fwd1_data, 32'h2);
    check("t4_hit2_r0", {31'd0, fwd2_hit}, 32'd0);
    check("t4_data2_r0", fwd2_data, 32'd0);
    rs2 = 5'd3;
    #1 check("t4_hit2_miss", {31'd0, fwd2_hit}, 32'd0);
    port_busy = 1'b0;
    #1;
    check("t4_hit_head_pop", {31'd0, fwd1_hit}, 32'd1);
    check("t4_data_head_pop", fwd1_data, 32'h2);
    tick();
    check("t4_hit_last", {31'd0, fwd1_hit}, 32'd1);
    check("t4_data_last", fwd1_data, 32'h2);
    tick();
    check("t4_hit_gone", {31'd0, fwd1_hit}, 32'd0);
    check("t4_data_gone", fwd1_data, 32'd0);
    rs1 = 5'd0; rs2 = 5'd0;

    // r0 writes are acknowledged and dropped.
    alu_req(1'b1, 5'd0, 32'hFFFF);
    #1 check("t5_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_req(1'b0, 5'd0, 32'd0);
    #1;
    check("t5_pending", {29'd0, pending}, 32'd0);
    check("t5_we3_a", {31'd0, WE3}, 32'd0);
    tick();
    check("t5_we3_b", {31'd0, WE3}, 32'd0);

    // Asynchronous reset mid-cycle discards queued writes.
    port_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alu_req(1'b1, 5'(10 + k), 32'(32'hA + k));
      tick();
    end
    alu_req(1'b0, 5'd0, 32'd0);
    rs1 = 5'd11;
    #1;
    check("t6_pending3", {29'd0, pending}, 32'd3);
    check("t6_hit_pre", {31'd0, fwd1_hit}, 32'd1);
    port_busy = 1'b0;
    #1 check("t6_we3_pre", {31'd0, WE3}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_we3_rst", {31'd0, WE3}, 32'd0);
    check("t6_pending_rst", {29'd0, pending}, 32'd0);
    check("t6_hit_rst", {31'd0, fwd1_hit}, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("t6_no_write_%0d", k), {31'd0, WE3}, 32'd0);
      tick();
    end
    check("t6_pending_after", {29'd0, pending}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-side initiator for the register file's single write port (AD3/WE3/WD3).
- Collects writeback requests from the ALU path and the load path and buffers them in a small in-order queue.
- Drains one entry per cycle into the register file unless the port is borrowed.
- Provides forwarding lookups so that reads through AD1/AD2 see data still pending in the queue.

Parameters:
- DATA_WIDTH, 32, width of register data.
- ADDRESS_WIDTH, 5, width of register index (32 registers).
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_rd  input  ADDRESS_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- alu_ready  output  1  ALU request accepted this cycle.
- ld_valid  input  1  load writeback request.
- ld_rd  input  ADDRESS_WIDTH  load destination register.
- ld_data  input  DATA_WIDTH  load data.
- ld_ready  output  1  load request accepted this cycle.
- port_busy  input  1  write port borrowed externally; suppresses drain.
- WE3  output  1  register-file write enable.
- AD3  output  ADDRESS_WIDTH  register-file write address.
- WD3  output  DATA_WIDTH  register-file write data.
- rs1  input  ADDRESS_WIDTH  forwarding lookup 1 (same value as AD1).
- rs2  input  ADDRESS_WIDTH  forwarding lookup 2 (same value as AD2).
- fwd1_hit  output  1  rs1 matches a pending entry.
- fwd1_data  output  DATA_WIDTH  youngest pending data for rs1.
- fwd2_hit  output  1  rs2 matches a pending entry.
- fwd2_data  output  DATA_WIDTH  youngest pending data for rs2.
- pending  output  clog2(DEPTH)+1  number of queued entries.

Behaviour:
- Storage: circular buffer with head/tail pointers and count; each entry is {rd, data}.
- Reset (async, rst=1):
  - count, head and tail go to 0; all entries are invalidated.
  - WE3=0, AD3=0, WD3=0, fwd*_hit=0, fwd*_data=0, pending=0.
  - Reset mid-operation discards all pending writes; nothing is written to the register file.
- Drain:
  - pop = (count>0) && !port_busy.
  - WE3 = pop; AD3/WD3 carry the head entry combinationally; AD3/WD3 are 0 when count=0.
  - The register file captures the write on the same rising edge; the head pointer advances on that edge.
- Space:
  - space = (count<DEPTH) || pop.
  - A full queue accepts a new entry in the same cycle it pops.
- Arbitration:
  - ld_ready = space.
  - alu_ready = space && !ld_valid. Load has fixed priority; the ALU holds its request until ready.
  - At most one enqueue per cycle.
- Enqueue:
  - Occurs on the rising edge when valid&&ready.
  - rd=0 requests are accepted (ready as above) but not stored; count is unchanged.
- Count update:
  - count_next = count + enq_stored - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency:
  - An accepted entry into an empty queue (port free) appears on WE3 the cycle after acceptance.
  - That register is readable from the register file the cycle after that.
- Forwarding (combinational):
  - hit when rsN != 0 and some valid entry has rd == rsN.
  - With multiple matches, data comes from the youngest entry (closest to tail).
  - The head entry being written this cycle still counts as a hit.
  - Entries enqueued on the current edge are visible from the next cycle.
  - On a miss, fwdN_data=0.
- pending = count, registered.
- No error outputs. A valid request with ready=0 must be held stable by the source; that is a source obligation, not checked here.

Test Plan:
- Reset then single ALU write, alu_rd=5, alu_data=0xDEADBEEF, port free -> next cycle WE3=1, AD3=5, WD3=0xDEADBEEF for one cycle; pending 1->0.
- ld_valid and alu_valid together (ld_rd=3/0x11, alu_rd=4/0x22) -> ld_ready=1, alu_ready=0; load drains first, ALU second on the following cycle; pending never exceeds 1.
- port_busy=1 while issuing 5 ALU writes to r1..r5 (DEPTH=4) -> 4 accepted, 5th sees alu_ready=0, pending=4; release port_busy -> WE3 on r1..r4 in order; 5th accepted in the first release cycle (push+pop), pending stays 4.
- Write r7=0x1 then r7=0x2 while busy, rs1=7 -> fwd1_hit=1, fwd1_data=0x2; rs2=0 -> fwd2_hit=0; after drain completes -> fwd1_hit=0.
- alu_rd=0, alu_data=0xFFFF -> alu_ready=1, pending stays 0, WE3 never asserts.
- 3 entries queued with port_busy=1, assert rst asynchronously mid-cycle -> WE3, pending and fwd*_hit go to 0 immediately; after release, no write to any register occurs.
